// File: rtl/fpu_scoreboard_if.sv
// Operation encoding shared by decode and the FPU scoreboard, plus the
// decode/issue/writeback bundle that connects them.
package fpu_scoreboard_pkg;
    typedef enum logic [4:0] {
        FPU_OP_INVALID = 5'd0,
        FPU_OP_ADD,
        FPU_OP_SUB,
        FPU_OP_MUL,
        FPU_OP_DIV,
        FPU_OP_SQRT,
        FPU_OP_ROUND,
        FPU_OP_TRUNC,
        FPU_OP_CEIL,
        FPU_OP_FLOOR,
        FPU_OP_CVTS,
        FPU_OP_CVTW,
        FPU_OP_COND,
        FPU_OP_LW,
        FPU_OP_SW,
        FPU_OP_MTC,
        FPU_OP_MFC,
        FPU_OP_CTC,
        FPU_OP_CFC
    } FPUOper_t;
endpackage

interface fpu_scoreboard_if;
    import fpu_scoreboard_pkg::*;

    logic        flush;
    logic        id_valid;
    FPUOper_t    id_op;
    logic [4:0]  id_raddr1;
    logic [4:0]  id_raddr2;
    logic        id_we;
    logic [4:0]  id_waddr;
    logic        issue_o;
    logic        stall_o;
    logic        wb_valid_o;
    logic [4:0]  wb_addr_o;
    logic [31:0] busy_o;
    logic        div_busy_o;

    modport master (
        output flush, id_valid, id_op, id_raddr1, id_raddr2, id_we, id_waddr,
        input  issue_o, stall_o, wb_valid_o, wb_addr_o, busy_o, div_busy_o
    );

    modport slave (
        input  flush, id_valid, id_op, id_raddr1, id_raddr2, id_we, id_waddr,
        output issue_o, stall_o, wb_valid_o, wb_addr_o, busy_o, div_busy_o
    );
endinterface

// File: rtl/fpu_scoreboard.sv
// FPU issue scoreboard: per-FPR latency counters, writeback-slot queue,
// divider occupancy and fcc-pending tracking; decides issue vs. stall.
module fpu_scoreboard
    import fpu_scoreboard_pkg::*;
(
    input logic               clk,
    input logic               rst,
    fpu_scoreboard_if.slave   sb
);

    logic [3:0]  cnt [32];
    logic [15:0] slot_vld;
    logic [4:0]  slot_addr [16];
    logic [3:0]  div_cnt;
    logic [1:0]  fcc_cnt;

    logic [3:0]  lat;
    logic [3:0]  lat_m1;
    logic        use1, use2, is_div, is_ctl, is_cond, invalid;
    logic        track, hazard, live, issue;
    logic [31:0] busy;

    always_comb begin
        lat     = 4'd0;
        use1    = 1'b0;
        use2    = 1'b0;
        is_div  = 1'b0;
        is_ctl  = 1'b0;
        is_cond = 1'b0;
        invalid = 1'b0;
        case (sb.id_op)
            FPU_OP_ADD, FPU_OP_SUB: begin lat = 4'd3; use1 = 1'b1; use2 = 1'b1; end
            FPU_OP_MUL:             begin lat = 4'd4; use1 = 1'b1; use2 = 1'b1; end
            FPU_OP_DIV:  begin lat = 4'd10; use1 = 1'b1; use2 = 1'b1; is_div = 1'b1; end
            FPU_OP_SQRT: begin lat = 4'd10; use1 = 1'b1; is_div = 1'b1; end
            FPU_OP_ROUND, FPU_OP_TRUNC, FPU_OP_CEIL, FPU_OP_FLOOR,
            FPU_OP_CVTS, FPU_OP_CVTW: begin lat = 4'd2; use1 = 1'b1; end
            FPU_OP_COND: begin lat = 4'd2; use1 = 1'b1; use2 = 1'b1; is_cond = 1'b1; end
            FPU_OP_LW, FPU_OP_MTC:  lat = 4'd1;
            FPU_OP_SW:              use1 = 1'b1;
            FPU_OP_MFC:             use2 = 1'b1;
            FPU_OP_CTC, FPU_OP_CFC: is_ctl = 1'b1;
            default:                invalid = 1'b1;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            busy[i] = (cnt[i] != 4'd0);
        end
    end

    // Only ops with a defined FPR latency occupy a counter and a writeback slot.
    assign track  = sb.id_we && !is_ctl && (lat != 4'd0);
    assign lat_m1 = lat - 4'd1;

    // slot_vld[k] means some FPR writes back k cycles from now, so an op issued
    // now with latency L collides with whatever sits at index L.
    assign hazard = (use1 && busy[sb.id_raddr1])
                  || (use2 && busy[sb.id_raddr2])
                  || (track && busy[sb.id_waddr])
                  || (track && slot_vld[lat])
                  || (is_div && (div_cnt != 4'd0))
                  || (is_ctl && ((|busy) || (|slot_vld) || (div_cnt != 4'd0) || (fcc_cnt != 2'd0)));

    assign live  = sb.id_valid && !sb.flush && !invalid && !rst;
    assign issue = live && !hazard;

    assign sb.issue_o    = issue;
    assign sb.stall_o    = live && hazard;
    assign sb.wb_valid_o = slot_vld[0];
    assign sb.wb_addr_o  = slot_vld[0] ? slot_addr[0] : 5'd0;
    assign sb.busy_o     = busy;
    assign sb.div_busy_o = (div_cnt != 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                cnt[i] <= 4'd0;
            end
            for (int k = 0; k < 16; k++) begin
                slot_addr[k] <= 5'd0;
            end
            slot_vld <= 16'd0;
            div_cnt  <= 4'd0;
            fcc_cnt  <= 2'd0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (issue && track && (sb.id_waddr == 5'(i))) begin
                    cnt[i] <= lat;
                end else if (cnt[i] != 4'd0) begin
                    cnt[i] <= cnt[i] - 4'd1;
                end
            end

            for (int k = 0; k < 15; k++) begin
                slot_vld[k]  <= slot_vld[k+1];
                slot_addr[k] <= slot_addr[k+1];
            end
            slot_vld[15]  <= 1'b0;
            slot_addr[15] <= 5'd0;
            if (issue && track) begin
                slot_vld[lat_m1]  <= 1'b1;
                slot_addr[lat_m1] <= sb.id_waddr;
            end

            if (issue && is_div) begin
                div_cnt <= 4'd10;
            end else if (div_cnt != 4'd0) begin
                div_cnt <= div_cnt - 4'd1;
            end

            if (issue && is_cond) begin
                fcc_cnt <= 2'd2;
            end else if (fcc_cnt != 2'd0) begin
                fcc_cnt <= fcc_cnt - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_fpu_scoreboard.sv
// Directed bench for fpu_scoreboard: latency, RAW/WAW/structural/divider/
// control hazards, flush and reset behaviour with hand-computed expectations.
module tb_fpu_scoreboard;
    import fpu_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    fpu_scoreboard_if bus();

    fpu_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input FPUOper_t op, input logic [4:0] a1,
                         input logic [4:0] a2, input logic we, input logic [4:0] wa);
        bus.id_valid  = v;
        bus.id_op     = op;
        bus.id_raddr1 = a1;
        bus.id_raddr2 = a2;
        bus.id_we     = we;
        bus.id_waddr  = wa;
    endtask

    task automatic idle();
        drive(1'b0, FPU_OP_INVALID, 5'd0, 5'd0, 1'b0, 5'd0);
        bus.flush = 1'b0;
    endtask

    task automatic drain(input int n);
        idle();
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, FPU_OP_ADD, 5'd1, 5'd2, 1'b1, 5'd3);
        tick();
        tick();
        checks++;
        if (bus.issue_o !== 1'b0 || bus.stall_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_issue: got issue=%b stall=%b expected 0 0", bus.issue_o, bus.stall_o);
        end
        checks++;
        if (bus.busy_o !== 32'd0 || bus.div_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got busy=%h div=%b expected 0 0", bus.busy_o, bus.div_busy_o);
        end
        checks++;
        if (bus.wb_valid_o !== 1'b0 || bus.wb_addr_o !== 5'd0) begin
            errors++;
            $display("FAIL reset_wb: got valid=%b addr=%0d expected 0 0", bus.wb_valid_o, bus.wb_addr_o);
        end
        rst = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_add_latency();
        drive(1'b1, FPU_OP_ADD, 5'd1, 5'd2, 1'b1, 5'd3);
        #1;
        checks++;
        if (bus.issue_o !== 1'b1) begin
            errors++;
            $display("FAIL add_issue: got %b expected 1", bus.issue_o);
        end
        for (int c = 1; c <= 4; c++) begin
            tick();
            idle();
            #1;
            checks++;
            if (bus.busy_o[3] !== (c <= 3)) begin
                errors++;
                $display("FAIL add_busy c=%0d: got %b expected %b", c, bus.busy_o[3], (c <= 3));
            end
            checks++;
            if (bus.wb_valid_o !== (c == 3) || bus.wb_addr_o !== ((c == 3) ? 5'd3 : 5'd0)) begin
                errors++;
                $display("FAIL add_wb c=%0d: got valid=%b addr=%0d expected %b %0d", c,
                         bus.wb_valid_o, bus.wb_addr_o, (c == 3), (c == 3) ? 3 : 0);
            end
        end
        drain(4);
    endtask

    task automatic test_raw();
        drive(1'b1, FPU_OP_ADD, 5'd1, 5'd2, 1'b1, 5'd3);
        tick();
        for (int c = 1; c <= 4; c++) begin
            drive(1'b1, FPU_OP_MUL, 5'd3, 5'd5, 1'b1, 5'd4);
            #1;
            checks++;
            if (bus.stall_o !== (c <= 3) || bus.issue_o !== (c == 4)) begin
                errors++;
                $display("FAIL raw c=%0d: got stall=%b issue=%b expected %b %b", c,
                         bus.stall_o, bus.issue_o, (c <= 3), (c == 4));
            end
            tick();
        end
        drain(8);
    endtask

    task automatic test_waw();
        drive(1'b1, FPU_OP_ADD, 5'd1, 5'd2, 1'b1, 5'd3);
        tick();
        for (int c = 1; c <= 4; c++) begin
            drive(1'b1, FPU_OP_LW, 5'd0, 5'd0, 1'b1, 5'd3);
            #1;
            checks++;
            if (bus.stall_o !== (c <= 3) || bus.issue_o !== (c == 4)) begin
                errors++;
                $display("FAIL waw c=%0d: got stall=%b issue=%b expected %b %b", c,
                         bus.stall_o, bus.issue_o, (c <= 3), (c == 4));
            end
            tick();
        end
        drain(4);
    endtask

    task automatic test_struct();
        drive(1'b1, FPU_OP_MUL, 5'd1, 5'd2, 1'b1, 5'd6);
        tick();
        idle();
        tick();
        drive(1'b1, FPU_OP_CVTW, 5'd1, 5'd0, 1'b1, 5'd7);
        #1;
        checks++;
        if (bus.stall_o !== 1'b1) begin
            errors++;
            $display("FAIL struct_stall: got %b expected 1", bus.stall_o);
        end
        tick();
        checks++;
        if (bus.issue_o !== 1'b1) begin
            errors++;
            $display("FAIL struct_issue: got %b expected 1", bus.issue_o);
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.wb_valid_o !== 1'b1 || bus.wb_addr_o !== 5'd6) begin
            errors++;
            $display("FAIL struct_wb4: got valid=%b addr=%0d expected 1 6", bus.wb_valid_o, bus.wb_addr_o);
        end
        tick();
        checks++;
        if (bus.wb_valid_o !== 1'b1 || bus.wb_addr_o !== 5'd7) begin
            errors++;
            $display("FAIL struct_wb5: got valid=%b addr=%0d expected 1 7", bus.wb_valid_o, bus.wb_addr_o);
        end
        tick();
        checks++;
        if (bus.wb_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL struct_wb6: got %b expected 0", bus.wb_valid_o);
        end
        drain(4);
    endtask

    task automatic test_div();
        drive(1'b1, FPU_OP_DIV, 5'd1, 5'd2, 1'b1, 5'd8);
        tick();
        for (int c = 1; c <= 11; c++) begin
            drive(1'b1, FPU_OP_SQRT, 5'd10, 5'd0, 1'b1, 5'd9);
            #1;
            checks++;
            if (bus.stall_o !== (c <= 10) || bus.issue_o !== (c == 11)) begin
                errors++;
                $display("FAIL div_stall c=%0d: got stall=%b issue=%b expected %b %b", c,
                         bus.stall_o, bus.issue_o, (c <= 10), (c == 11));
            end
            checks++;
            if (bus.div_busy_o !== (c <= 10)) begin
                errors++;
                $display("FAIL div_busy c=%0d: got %b expected %b", c, bus.div_busy_o, (c <= 10));
            end
            if (c == 10) begin
                checks++;
                if (bus.wb_valid_o !== 1'b1 || bus.wb_addr_o !== 5'd8) begin
                    errors++;
                    $display("FAIL div_wb: got valid=%b addr=%0d expected 1 8", bus.wb_valid_o, bus.wb_addr_o);
                end
            end
            tick();
        end
        drain(14);
    endtask

    task automatic test_ctl();
        drive(1'b1, FPU_OP_LW, 5'd0, 5'd0, 1'b1, 5'd5);
        tick();
        drive(1'b1, FPU_OP_MFC, 5'd5, 5'd0, 1'b0, 5'd0);
        #1;
        checks++;
        if (bus.issue_o !== 1'b1 || bus.stall_o !== 1'b0) begin
            errors++;
            $display("FAIL mfc_f0: got issue=%b stall=%b expected 1 0", bus.issue_o, bus.stall_o);
        end
        tick();
        drain(3);

        drive(1'b1, FPU_OP_COND, 5'd1, 5'd2, 1'b0, 5'd0);
        tick();
        for (int c = 1; c <= 3; c++) begin
            drive(1'b1, FPU_OP_CFC, 5'd0, 5'd0, 1'b0, 5'd0);
            #1;
            checks++;
            if (bus.stall_o !== (c <= 2) || bus.issue_o !== (c == 3)) begin
                errors++;
                $display("FAIL cfc_fcc c=%0d: got stall=%b issue=%b expected %b %b", c,
                         bus.stall_o, bus.issue_o, (c <= 2), (c == 3));
            end
            tick();
        end
        drain(3);

        drive(1'b1, FPU_OP_ADD, 5'd1, 5'd2, 1'b1, 5'd3);
        tick();
        drive(1'b1, FPU_OP_CTC, 5'd0, 5'd0, 1'b0, 5'd0);
        #1;
        checks++;
        if (bus.stall_o !== 1'b1) begin
            errors++;
            $display("FAIL ctc_busy: got %b expected 1", bus.stall_o);
        end
        drain(5);
    endtask

    task automatic test_invalid_flush();
        drive(1'b1, FPU_OP_INVALID, 5'd1, 5'd2, 1'b1, 5'd3);
        #1;
        checks++;
        if (bus.issue_o !== 1'b0 || bus.stall_o !== 1'b0) begin
            errors++;
            $display("FAIL invalid_op: got issue=%b stall=%b expected 0 0", bus.issue_o, bus.stall_o);
        end
        drive(1'b0, FPU_OP_ADD, 5'd1, 5'd2, 1'b1, 5'd3);
        #1;
        checks++;
        if (bus.issue_o !== 1'b0 || bus.stall_o !== 1'b0) begin
            errors++;
            $display("FAIL no_valid: got issue=%b stall=%b expected 0 0", bus.issue_o, bus.stall_o);
        end
        drive(1'b1, FPU_OP_ADD, 5'd1, 5'd2, 1'b1, 5'd3);
        tick();
        drive(1'b1, FPU_OP_MUL, 5'd3, 5'd5, 1'b1, 5'd4);
        bus.flush = 1'b1;
        #1;
        checks++;
        if (bus.issue_o !== 1'b0 || bus.stall_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_out: got issue=%b stall=%b expected 0 0", bus.issue_o, bus.stall_o);
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.busy_o[3] !== 1'b1 || bus.busy_o[4] !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy: got f3=%b f4=%b expected 1 0", bus.busy_o[3], bus.busy_o[4]);
        end
        tick();
        checks++;
        if (bus.wb_valid_o !== 1'b1 || bus.wb_addr_o !== 5'd3) begin
            errors++;
            $display("FAIL flush_drain: got valid=%b addr=%0d expected 1 3", bus.wb_valid_o, bus.wb_addr_o);
        end
        drain(4);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, FPU_OP_DIV, 5'd1, 5'd2, 1'b1, 5'd8);
        tick();
        idle();
        repeat (3) tick();
        rst = 1'b1;
        drive(1'b1, FPU_OP_ADD, 5'd1, 5'd2, 1'b1, 5'd11);
        #1;
        checks++;
        if (bus.issue_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_issue: got %b expected 0", bus.issue_o);
        end
        tick();
        rst = 1'b0;
        idle();
        #1;
        checks++;
        if (bus.busy_o !== 32'd0 || bus.div_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_busy: got busy=%h div=%b expected 0 0", bus.busy_o, bus.div_busy_o);
        end
        for (int c = 5; c <= 15; c++) begin
            checks++;
            if (bus.wb_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_wb c=%0d: got %b expected 0", c, bus.wb_valid_o);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_add_latency();
        test_raw();
        test_waw();
        test_struct();
        test_div();
        test_ctl();
        test_invalid_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpu_scoreboard.md
FPU_SCOREBOARD -- requirements
Module: fpu_scoreboard

Interface
REQ-001 SHALL have ports: clk  in  1  system clock (rising edge).
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: flush  in  1  kill the instruction currently in decode; it is not issued.
REQ-004 SHALL have: id_valid  in  1  decoded FPU instruction present.
REQ-005 SHALL have: id_op  in  FPUOper_t  decoded FPU operation.
REQ-006 SHALL have: id_raddr1, id_raddr2  in  5 each  decoded source FPR addresses.
REQ-007 SHALL have: id_we  in  1  and  id_waddr  in  5  decoded FPR write enable and address.
REQ-008 SHALL have: issue_o  out  1  instruction issues this cycle.
REQ-009 SHALL have: stall_o  out  1  hold decode stage.
REQ-010 SHALL have: wb_valid_o  out  1  and  wb_addr_o  out  5  scheduled writeback this cycle.
REQ-011 SHALL have: busy_o  out  32  per-FPR pending-write flags.
REQ-012 SHALL have: div_busy_o  out  1  unpipelined DIV/SQRT unit occupied.

Function
REQ-013 Latency L SHALL be: LW/MTC 1; ROUND/TRUNC/CEIL/FLOOR/CVTS/CVTW/COND 2; ADD/SUB 3; MUL 4; DIV/SQRT 10.
REQ-014 Source use SHALL be: ADD/SUB/MUL/DIV/COND: raddr1 and raddr2; SQRT/ROUND/TRUNC/CEIL/FLOOR/CVTS/CVTW/SW: raddr1 only; MFC: raddr2 only; LW/MTC/CTC/CFC: none. Unused addresses SHALL be ignored, so f0 placeholders create no hazard.
REQ-015 FPR tracking SHALL use id_we/id_waddr, except CTC and CFC, which target control registers and never touch the FPR scoreboard.
REQ-016 Each FPR SHALL have a 4-bit counter. Issue at cycle T with id_we loads L, visible from T+1. Nonzero counters decrement every cycle.
REQ-017 busy_o[i] SHALL equal (cnt[i] != 0).
REQ-018 wb_valid_o SHALL be 1 in cycle T+L with wb_addr_o = id_waddr of the op issued at T. Otherwise wb_valid_o = 0 and wb_addr_o = 0.
REQ-019 RAW stall: any used source with cnt != 0. There is no bypass, so a dependent op issues no earlier than T+L+1.
REQ-020 WAW stall: id_we and cnt[id_waddr] != 0.
REQ-021 Structural stall: an outstanding op already holds the writeback slot at T+L. This is tracked in a 16-entry slot queue (valid + 5-bit addr) shifted every cycle.
REQ-022 DIV/SQRT SHALL occupy the divider for 10 cycles (T+1..T+10, div_busy_o = 1). A DIV/SQRT arriving while div_busy_o = 1 SHALL stall.
REQ-023 COND SHALL set a 2-cycle fcc-pending counter. CFC and CTC SHALL stall until all FPR counters, the slot queue, the divider and fcc-pending are idle.
REQ-024 id_op = FPU_OP_INVALID, or id_valid = 0, SHALL give issue_o = 0 and stall_o = 0.
REQ-025 issue_o SHALL equal id_valid & ~flush & ~stall_o & ~invalid.
REQ-026 stall_o SHALL equal id_valid & ~flush & (any hazard in REQ-019..023).
REQ-027 flush SHALL NOT cancel already-issued ops: counters, slots and the divider continue to drain.
REQ-028 Writeback and a new issue to the same FPR in the same cycle cannot coexist (WAW stall). Decrement and load on different registers SHALL be independent.
REQ-029 All outputs SHALL be registered-state derived or combinational from current inputs and state. There is no internal buffering of stalled instructions.

Reset
REQ-030 When rst = 1 at a clock edge, all counters, the slot queue, the divider counter and fcc-pending SHALL clear to 0.
REQ-031 While rst = 1, issue_o, stall_o, wb_valid_o, wb_addr_o, busy_o and div_busy_o SHALL read 0 in the following cycle.
REQ-032 Reset SHALL take effect mid-operation, discarding all pending writebacks.

Verification
REQ-033 ADD f3 <- f1,f2 issued at cycle 0 -> busy_o[3] = 1 in cycles 1-3; wb_valid_o = 1 with wb_addr_o = 3 at cycle 3; busy_o[3] = 0 at cycle 4.
REQ-034 ADD f3 at cycle 0, then MUL f4 <- f3,f5 presented at cycle 1 -> stall_o = 1 in cycles 1-3; issue_o = 1 at cycle 4.
REQ-035 MUL f6 at cycle 0 (wb cycle 4), then CVTW f7 presented at cycle 2 (wb cycle 4) -> stall_o = 1 at cycle 2; issue at cycle 3, writeback at cycle 5.
REQ-036 DIV f8 at cycle 0, then SQRT f9 presented at cycle 1 -> stalled through cycle 10; issue_o = 1 at cycle 11.
REQ-037 MFC reading f0 with no pending writes -> issue_o = 1 with no stall. CFC presented one cycle after COND -> stall_o = 1 until fcc-pending clears.
REQ-038 DIV f8 at cycle 0, then rst at cycle 4 -> cycle 5 shows busy_o = 0, div_busy_o = 0, and no wb_valid_o ever for f8.
